// File: rtl/decade_press_counter_pkg.sv
// ---------------------------------------------------------------------------
// decade_press_counter_pkg
//
// Shared constants and helpers for the debounced push-button decade counter.
// The count width lives here so the counter and the downstream
// binary-to-seven-segment decoder always agree on the bus width.
//
// Contents:
//   COUNT_WIDTH            - width of the count bus fed to the decoder
//   DEFAULT_DEBOUNCE_LIMIT - stable cycles before the filtered state moves
//   DEFAULT_MAX_COUNT      - highest count before wrapping to 0
//   DEFAULT_TICK_LIMIT     - auto-tick period (COUNTER_AUTO_TICK_EN builds)
//   count_t                - count value type
//   count_step_t           - next count value plus its wrap carry
//   count_step()           - wrapping increment helper
// ---------------------------------------------------------------------------
package decade_press_counter_pkg;

    localparam int COUNT_WIDTH            = 4;
    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;    // 10 ms at 25 MHz
    localparam int DEFAULT_MAX_COUNT      = 9;
    localparam int DEFAULT_TICK_LIMIT     = 25000000;  // 1 s at 25 MHz

    typedef logic [COUNT_WIDTH-1:0] count_t;

    typedef struct packed {
        count_t count;
        logic   carry;
    } count_step_t;

    // Increment with wrap: reaching max_count rolls back to zero and
    // raises carry so a following digit stage can advance.
    function automatic count_step_t count_step(input count_t cur,
                                               input count_t max_count);
        count_step_t step;
        if (cur >= max_count) begin
            step.count = '0;
            step.carry = 1'b1;
        end else begin
            step.count = cur + count_t'(1);
            step.carry = 1'b0;
        end
        return step;
    endfunction

endpackage

// File: rtl/decade_press_counter_debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
//
// Two-flop synchroniser followed by a stability-counting debounce filter.
// The filtered output only changes once the synchronised level has differed
// from it for DEBOUNCE_LIMIT consecutive cycles; any return to the current
// filtered level restarts the count.
//
// Parameters:
//   DEBOUNCE_LIMIT - consecutive differing cycles needed to change state
//
// Ports:
//   i_Clk       - system clock, rising edge
//   i_Rst_L     - synchronous active-low reset
//   i_Raw       - raw, asynchronous, bouncing switch level (1 = pressed)
//   o_Debounced - filtered switch level
// ---------------------------------------------------------------------------
module debounce_filter
    import decade_press_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Debounced
);

    // A limit of 1 still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
        $error("debounce_filter: DEBOUNCE_LIMIT must be at least 1");
    end

    logic             sync_meta;
    logic             sync_level;
    logic             debounced;
    logic [CNT_W-1:0] stable_cnt;

    // i_Raw is asynchronous; the first flop may go metastable, so only the
    // second flop's output is ever used.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= i_Raw;
            sync_level <= sync_meta;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // filtered state; agreement (a bounce back) clears it.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            debounced  <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_level == debounced) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            debounced  <= sync_level;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    assign o_Debounced = debounced;

endmodule

// File: rtl/decade_press_counter.sv
// ---------------------------------------------------------------------------
// decade_press_counter
//
// Debounced push-button counter feeding a binary-to-seven-segment decoder.
// A press is counted when the debounced button is released (debounced
// falling edge). The count wraps from MAX_COUNT to 0 and raises o_Carry for
// exactly that cycle so a second digit stage can be chained.
//
// Optional feature (macro COUNTER_AUTO_TICK_EN):
//   When defined, a free-running tick counter (0..TICK_LIMIT-1) issues an
//   increment request on its terminal cycle. A press and a tick landing in
//   the same cycle produce one increment. Presses never restart the tick.
//   When undefined, there is no tick logic and TICK_LIMIT has no effect.
//
// Parameters:
//   DEBOUNCE_LIMIT - stable cycles before the filtered switch state changes
//   MAX_COUNT      - highest count before wrap (1..15)
//   TICK_LIMIT     - auto-tick period in cycles (COUNTER_AUTO_TICK_EN only)
//
// Ports:
//   i_Clk    - system clock, rising edge
//   i_Rst_L  - synchronous active-low reset
//   i_Switch - raw push-button level, 1 = pressed, asynchronous
//   o_Count  - registered count, 0..MAX_COUNT
//   o_Carry  - one-cycle pulse coincident with o_Count wrapping to 0
// ---------------------------------------------------------------------------
module decade_press_counter
    import decade_press_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int MAX_COUNT      = DEFAULT_MAX_COUNT,
    parameter int TICK_LIMIT     = DEFAULT_TICK_LIMIT
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Switch,
    output logic [COUNT_WIDTH-1:0] o_Count,
    output logic                   o_Carry
);

    localparam count_t MAX_C = count_t'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > 15 || TICK_LIMIT < 1) begin : g_bad_cfg
        $error("decade_press_counter: MAX_COUNT must be 1..15 and TICK_LIMIT >= 1");
    end

    logic        debounced;
    logic        debounced_q;
    logic        press_done;
    logic        inc_req;
    count_t      count_q;
    logic        carry_q;
    count_step_t next_step;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Raw      (i_Switch),
        .o_Debounced(debounced)
    );

    // Counting on release means a button held forever yields exactly one
    // count, and only once the user lets go.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            debounced_q <= 1'b0;
        end else begin
            debounced_q <= debounced;
        end
    end

    assign press_done = debounced_q & ~debounced;

`ifdef COUNTER_AUTO_TICK_EN
    localparam int TICK_W = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_LIMIT - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_term;

    // Free-running; presses deliberately do not restart it.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick_term = (tick_cnt == TICK_LAST);

    // OR-ing the requests merges a coincident press and tick into one step.
    assign inc_req = press_done | tick_term;
`else
    assign inc_req = press_done;
`endif

    assign next_step = count_step(count_q, MAX_C);

    // Carry is a pulse: cleared every cycle unless this cycle wraps.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else if (inc_req) begin
            count_q <= next_step.count;
            carry_q <= next_step.carry;
        end else begin
            carry_q <= 1'b0;
        end
    end

    assign o_Count = count_q;
    assign o_Carry = carry_q;

endmodule

// File: tb/tb_decade_press_counter.sv
// ---------------------------------------------------------------------------
// tb_decade_press_counter
//
// Self-checking bench for decade_press_counter with DEBOUNCE_LIMIT = 4,
// MAX_COUNT = 9, TICK_LIMIT = 20. A behavioural model tracks the expected
// count and carry every cycle; directed sequences add checks on release
// latency, bounce rejection, wrap/carry and reset during a held press.
// Builds with and without COUNTER_AUTO_TICK_EN.
// ---------------------------------------------------------------------------
module tb_decade_press_counter;

    localparam int DL = 4;
    localparam int MC = 9;
    localparam int TL = 20;

    logic       clk = 1'b0;
    logic       rstL;
    logic       sw;
    logic [3:0] count;
    logic       carry;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int syncPipe[$];
    int filtHist[$];
    int mDeb;
    int mDebPrev;
    int mCount;
    int mCarry;
    int mEdges;

    int carrySeen;
    int countAtCarry;

    always #5 clk = ~clk;

    decade_press_counter #(
        .DEBOUNCE_LIMIT(DL),
        .MAX_COUNT     (MC),
        .TICK_LIMIT    (TL)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rstL),
        .i_Switch(sw),
        .o_Count (count),
        .o_Carry (carry)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Model of one rising edge. The filter sees the switch two samples
    // late; the debounced level flips once the last DL filter samples all
    // disagree with it; a count happens the edge after a debounced 1->0.
    function automatic void modelEdge(input int in, input int rst);
        int  filt;
        int  allDiffer;
        int  fall;
        int  inc;
        if (rst == 0) begin
            syncPipe = '{0, 0};
            filtHist.delete();
            mDeb     = 0;
            mDebPrev = 0;
            mCount   = 0;
            mCarry   = 0;
            mEdges   = 0;
            return;
        end
        mEdges++;
        fall = (mDebPrev == 1 && mDeb == 0) ? 1 : 0;
        inc  = fall;
`ifdef COUNTER_AUTO_TICK_EN
        if (mEdges % TL == 0) inc = 1;
`endif
        mCarry = 0;
        if (inc == 1) begin
            mCount = (mCount + 1) % (MC + 1);
            if (mCount == 0) mCarry = 1;
        end
        mDebPrev = mDeb;
        filt = syncPipe.pop_front();
        syncPipe.push_back(in);
        filtHist.push_back(filt);
        if (filtHist.size() > DL) void'(filtHist.pop_front());
        if (filtHist.size() == DL) begin
            allDiffer = 1;
            foreach (filtHist[k]) if (filtHist[k] == mDeb) allDiffer = 0;
            if (allDiffer == 1) mDeb = 1 - mDeb;
        end
    endfunction

    // Drives one cycle of inputs, advances the model, and compares the
    // outputs 1 time unit after the edge.
    task automatic applyStimulus(input bit s, input bit r);
        sw   = s;
        rstL = r;
        @(posedge clk);
        modelEdge(int'(s), int'(r));
        #1;
        checkOutput("count", count, mCount);
        checkOutput("carry", carry, mCarry);
        if (carry === 1'b1) begin
            carrySeen++;
            countAtCarry = int'(count);
        end
    endtask

    task automatic pressOnce(input int hold, input int rel);
        repeat (hold) applyStimulus(1'b1, 1'b1);
        repeat (rel)  applyStimulus(1'b0, 1'b1);
    endtask

    initial begin
        int lat;
        int runLen;
        bit lvl;
        bit bounceSeq[8];

        sw   = 1'b0;
        rstL = 1'b0;
        carrySeen    = 0;
        countAtCarry = 99;

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_carry", carry, 0);

`ifndef COUNTER_AUTO_TICK_EN
        carrySeen = 0;
        repeat (50) applyStimulus(1'b0, 1'b1);
        checkOutput("idle_count", count, 0);
        checkOutput("idle_carry_pulses", carrySeen, 0);

        // Clean press: count must appear on the 7th edge after release.
        repeat (10) applyStimulus(1'b1, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (count !== 4'd0) lat = i;
        end
        checkOutput("press_latency", lat, 7);
        checkOutput("press_count", count, 1);

        bounceSeq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        foreach (bounceSeq[i]) applyStimulus(bounceSeq[i], 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b1);
        checkOutput("bounce_count", count, 1);

        applyStimulus(1'b0, 1'b0);
        carrySeen    = 0;
        countAtCarry = 99;
        for (int i = 0; i < 10; i++) begin
            pressOnce(8, 10);
            checkOutput("step_count", count, (i + 1) % 10);
        end
        checkOutput("wrap_carry_pulses", carrySeen, 1);
        checkOutput("carry_with_zero", countAtCarry, 0);

        applyStimulus(1'b0, 1'b0);
        repeat (5) pressOnce(8, 10);
        checkOutput("pre_reset_count", count, 5);
        repeat (8) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midpress_reset", count, 0);
        repeat (10) applyStimulus(1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1);
        checkOutput("held_reset_count", count, 1);
`else
        applyStimulus(1'b0, 1'b0);
        repeat (60) applyStimulus(1'b0, 1'b1);
        checkOutput("tick_count_60", count, 3);

        // Release lands so the count update falls on edge 20, a tick edge.
        applyStimulus(1'b0, 1'b0);
        repeat (13) applyStimulus(1'b1, 1'b1);
        repeat (5)  applyStimulus(1'b0, 1'b1);
        checkOutput("tick_pre_merge", count, 0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("tick_press_merge", count, 1);
        repeat (20) applyStimulus(1'b0, 1'b1);
        checkOutput("tick_after_merge", count, 2);
`endif

        // Randomised runs of bouncing and stable levels with rare resets.
        applyStimulus(1'b0, 1'b0);
        for (int n = 0; n < 120; n++) begin
            lvl    = bit'($urandom_range(0, 1));
            runLen = int'($urandom_range(1, 9));
            for (int j = 0; j < runLen; j++) begin
                applyStimulus(lvl, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
